// File: rtl/sram_port_arbiter_if.sv
// Bundle of the two requester channels and the shared single-port SRAM command/response bus.
// slave = arbiter side, master = requesters plus SRAM macro side.
interface sram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  logic                  req0_i,    req1_i;
  logic                  we0_i,     we1_i;
  logic [NUM_WMASKS-1:0] wmask0_i,  wmask1_i;
  logic [ADDR_WIDTH-1:0] addr0_i,   addr1_i;
  logic [DATA_WIDTH-1:0] wdata0_i,  wdata1_i;
  logic                  gnt0_o,    gnt1_o;
  logic                  rvalid0_o, rvalid1_o;
  logic [DATA_WIDTH-1:0] rdata0_o,  rdata1_o;
  logic                  sram_csb,  sram_web;
  logic [NUM_WMASKS-1:0] sram_wmask;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic [DATA_WIDTH-1:0] sram_dout;

  modport slave (
    input  req0_i, req1_i, we0_i, we1_i, wmask0_i, wmask1_i,
           addr0_i, addr1_i, wdata0_i, wdata1_i, sram_dout,
    output gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata0_o, rdata1_o,
           sram_csb, sram_web, sram_wmask, sram_addr, sram_din
  );

  modport master (
    output req0_i, req1_i, we0_i, we1_i, wmask0_i, wmask1_i,
           addr0_i, addr1_i, wdata0_i, wdata1_i, sram_dout,
    input  gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata0_o, rdata1_o,
           sram_csb, sram_web, sram_wmask, sram_addr, sram_din
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter onto one single-port SRAM, with a fixed-latency
// response pipeline returning read data or write acks to the owning requester.
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int RD_LATENCY = 1
) (
  input logic                 clk,
  input logic                 rst,
  sram_port_arbiter_if.slave  bus
);
  localparam int unsigned LAST = RD_LATENCY - 1;

  logic                  prio_q, prio_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY-1:0] own_q, own_d;
  logic [RD_LATENCY-1:0] rd_q,  rd_d;
  logic                  gnt0, gnt1, gnt_any, resp_v;

  // prio names the requester that wins a tie; an uncontested request always wins.
  always_comb begin
    gnt0    = !rst && bus.req0_i && (!bus.req1_i || !prio_q);
    gnt1    = !rst && bus.req1_i && (!bus.req0_i ||  prio_q);
    gnt_any = gnt0 || gnt1;
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt0)      prio_d = 1'b1;
    else if (gnt1) prio_d = 1'b0;

    vld_d    = '0;
    own_d    = '0;
    rd_d     = '0;
    vld_d[0] = gnt_any;
    own_d[0] = gnt1;
    rd_d[0]  = gnt1 ? !bus.we1_i : !bus.we0_i;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
      rd_d[i]  = rd_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
      vld_q  <= '0;
      own_q  <= '0;
      rd_q   <= '0;
    end else begin
      prio_q <= prio_d;
      vld_q  <= vld_d;
      own_q  <= own_d;
      rd_q   <= rd_d;
    end
  end

  always_comb begin
    bus.gnt0_o     = gnt0;
    bus.gnt1_o     = gnt1;
    bus.sram_csb   = 1'b1;
    bus.sram_web   = 1'b1;
    bus.sram_wmask = '0;
    bus.sram_addr  = '0;
    bus.sram_din   = '0;
    if (gnt0) begin
      bus.sram_csb   = 1'b0;
      bus.sram_web   = !bus.we0_i;
      bus.sram_wmask = bus.wmask0_i;
      bus.sram_addr  = bus.addr0_i;
      bus.sram_din   = bus.wdata0_i;
    end else if (gnt1) begin
      bus.sram_csb   = 1'b0;
      bus.sram_web   = !bus.we1_i;
      bus.sram_wmask = bus.wmask1_i;
      bus.sram_addr  = bus.addr1_i;
      bus.sram_din   = bus.wdata1_i;
    end
  end

  // Response outputs are masked during rst so a discarded in-flight grant never shows.
  always_comb begin
    resp_v        = vld_q[LAST] && !rst;
    bus.rvalid0_o = resp_v && !own_q[LAST];
    bus.rvalid1_o = resp_v &&  own_q[LAST];
    bus.rdata0_o  = '0;
    bus.rdata1_o  = '0;
    if (bus.rvalid0_o && rd_q[LAST]) bus.rdata0_o = bus.sram_dout;
    if (bus.rvalid1_o && rd_q[LAST]) bus.rdata1_o = bus.sram_dout;
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Cycle-by-cycle directed vectors for the SRAM port arbiter (RD_LATENCY=2),
// followed by a write-then-read latency sequence.
module tb_sram_port_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int NV = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) bus ();

  sram_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW), .RD_LATENCY(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          rst;
    logic [1:0]    req;   // [0]=req0, [1]=req1
    logic [1:0]    we;
    logic [AW-1:0] a0, a1;
    logic [MW-1:0] m0, m1;
    logic [DW-1:0] d0, d1, dout;
    logic [1:0]    g;     // expected {gnt1,gnt0}
    logic [AW-1:0] sa;
    logic [MW-1:0] sm;
    logic [DW-1:0] sd;
    logic          web;
    logic [1:0]    v;     // expected {rvalid1,rvalid0}
    logic [DW-1:0] q0, q1;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mk(
    input logic r, input logic [1:0] req, input logic [1:0] we,
    input logic [AW-1:0] a0, input logic [MW-1:0] m0, input logic [DW-1:0] d0,
    input logic [AW-1:0] a1, input logic [MW-1:0] m1, input logic [DW-1:0] d1,
    input logic [DW-1:0] dout, input logic [1:0] g,
    input logic [AW-1:0] sa, input logic [MW-1:0] sm, input logic [DW-1:0] sd,
    input logic web, input logic [1:0] v, input logic [DW-1:0] q0, input logic [DW-1:0] q1);
    vec_t t;
    t.rst = r; t.req = req; t.we = we;
    t.a0 = a0; t.m0 = m0; t.d0 = d0; t.a1 = a1; t.m1 = m1; t.d1 = d1;
    t.dout = dout; t.g = g; t.sa = sa; t.sm = sm; t.sd = sd; t.web = web;
    t.v = v; t.q0 = q0; t.q1 = q1;
    return t;
  endfunction

  function automatic vec_t idle(input logic r, input logic [DW-1:0] dout,
                                input logic [1:0] v, input logic [DW-1:0] q0,
                                input logic [DW-1:0] q1);
    return mk(r, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0, dout, 2'b00,
              '0, '0, '0, 1'b1, v, q0, q1);
  endfunction

  task automatic check(input string nm, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst          = t.rst;
    bus.req0_i   = t.req[0];  bus.req1_i   = t.req[1];
    bus.we0_i    = t.we[0];   bus.we1_i    = t.we[1];
    bus.addr0_i  = t.a0;      bus.addr1_i  = t.a1;
    bus.wmask0_i = t.m0;      bus.wmask1_i = t.m1;
    bus.wdata0_i = t.d0;      bus.wdata1_i = t.d1;
    bus.sram_dout = t.dout;
  endtask

  initial begin
    int first_i, second_i, nresp;
    logic [DW-1:0] r_first, r_second;

    vt[0]  = mk(1, 2'b11, 2'b00, 11'h005, 4'h0, 32'h0, 11'h020, 4'h0, 32'h0, 32'h0,
                2'b00, 11'h000, 4'h0, 32'h0, 1, 2'b00, 32'h0, 32'h0);
    vt[1]  = idle(1, 32'h0, 2'b00, 32'h0, 32'h0);
    vt[2]  = mk(0, 2'b01, 2'b00, 11'h005, 4'h0, 32'h0, 11'h000, 4'h0, 32'h0, 32'h0,
                2'b01, 11'h005, 4'h0, 32'h0, 1, 2'b00, 32'h0, 32'h0);
    vt[3]  = idle(0, 32'h0, 2'b00, 32'h0, 32'h0);
    vt[4]  = idle(0, 32'h11110004, 2'b01, 32'h11110004, 32'h0);
    vt[5]  = idle(1, 32'h0, 2'b00, 32'h0, 32'h0);
    vt[6]  = mk(0, 2'b11, 2'b00, 11'h010, 4'h0, 32'h0, 11'h020, 4'h0, 32'h0, 32'hD0000006,
                2'b01, 11'h010, 4'h0, 32'h0, 1, 2'b00, 32'h0, 32'h0);
    vt[7]  = mk(0, 2'b11, 2'b00, 11'h010, 4'h0, 32'h0, 11'h020, 4'h0, 32'h0, 32'hD0000007,
                2'b10, 11'h020, 4'h0, 32'h0, 1, 2'b00, 32'h0, 32'h0);
    vt[8]  = mk(0, 2'b11, 2'b00, 11'h010, 4'h0, 32'h0, 11'h020, 4'h0, 32'h0, 32'hD0000008,
                2'b01, 11'h010, 4'h0, 32'h0, 1, 2'b01, 32'hD0000008, 32'h0);
    vt[9]  = mk(0, 2'b11, 2'b00, 11'h010, 4'h0, 32'h0, 11'h020, 4'h0, 32'h0, 32'hD0000009,
                2'b10, 11'h020, 4'h0, 32'h0, 1, 2'b10, 32'h0, 32'hD0000009);
    vt[10] = mk(0, 2'b11, 2'b00, 11'h010, 4'h0, 32'h0, 11'h020, 4'h0, 32'h0, 32'hD000000A,
                2'b01, 11'h010, 4'h0, 32'h0, 1, 2'b01, 32'hD000000A, 32'h0);
    vt[11] = mk(0, 2'b11, 2'b00, 11'h010, 4'h0, 32'h0, 11'h020, 4'h0, 32'h0, 32'hD000000B,
                2'b10, 11'h020, 4'h0, 32'h0, 1, 2'b10, 32'h0, 32'hD000000B);
    vt[12] = idle(0, 32'hD000000C, 2'b01, 32'hD000000C, 32'h0);
    vt[13] = idle(0, 32'hD000000D, 2'b10, 32'h0, 32'hD000000D);
    vt[14] = mk(0, 2'b10, 2'b10, 11'h000, 4'h0, 32'h0, 11'h7FF, 4'b0011, 32'hDEADBEEF, 32'h0,
                2'b10, 11'h7FF, 4'b0011, 32'hDEADBEEF, 0, 2'b00, 32'h0, 32'h0);
    vt[15] = mk(0, 2'b01, 2'b00, 11'h001, 4'h0, 32'h0, 11'h000, 4'h0, 32'h0, 32'h0,
                2'b01, 11'h001, 4'h0, 32'h0, 1, 2'b00, 32'h0, 32'h0);
    vt[16] = mk(0, 2'b01, 2'b00, 11'h002, 4'h0, 32'h0, 11'h000, 4'h0, 32'h0, 32'hBADBAD16,
                2'b01, 11'h002, 4'h0, 32'h0, 1, 2'b10, 32'h0, 32'h0);
    vt[17] = mk(0, 2'b01, 2'b00, 11'h003, 4'h0, 32'h0, 11'h000, 4'h0, 32'h0, 32'hC0000017,
                2'b01, 11'h003, 4'h0, 32'h0, 1, 2'b01, 32'hC0000017, 32'h0);
    vt[18] = mk(0, 2'b01, 2'b00, 11'h004, 4'h0, 32'h0, 11'h000, 4'h0, 32'h0, 32'hC0000018,
                2'b01, 11'h004, 4'h0, 32'h0, 1, 2'b01, 32'hC0000018, 32'h0);
    vt[19] = mk(0, 2'b11, 2'b00, 11'h100, 4'h0, 32'h0, 11'h200, 4'h0, 32'h0, 32'hC0000019,
                2'b10, 11'h200, 4'h0, 32'h0, 1, 2'b01, 32'hC0000019, 32'h0);
    vt[20] = mk(0, 2'b11, 2'b00, 11'h100, 4'h0, 32'h0, 11'h200, 4'h0, 32'h0, 32'hC0000020,
                2'b01, 11'h100, 4'h0, 32'h0, 1, 2'b01, 32'hC0000020, 32'h0);
    vt[21] = idle(0, 32'hC0000021, 2'b10, 32'h0, 32'hC0000021);
    vt[22] = idle(0, 32'hC0000022, 2'b01, 32'hC0000022, 32'h0);
    vt[23] = mk(0, 2'b01, 2'b00, 11'h055, 4'h0, 32'h0, 11'h000, 4'h0, 32'h0, 32'h0,
                2'b01, 11'h055, 4'h0, 32'h0, 1, 2'b00, 32'h0, 32'h0);
    vt[24] = mk(1, 2'b10, 2'b00, 11'h000, 4'h0, 32'h0, 11'h300, 4'h0, 32'h0, 32'hE0000024,
                2'b00, 11'h000, 4'h0, 32'h0, 1, 2'b00, 32'h0, 32'h0);
    vt[25] = mk(0, 2'b11, 2'b00, 11'h066, 4'h0, 32'h0, 11'h300, 4'h0, 32'h0, 32'hE0000025,
                2'b01, 11'h066, 4'h0, 32'h0, 1, 2'b00, 32'h0, 32'h0);
    vt[26] = idle(0, 32'hE0000026, 2'b00, 32'h0, 32'h0);
    vt[27] = idle(0, 32'hE0000027, 2'b01, 32'hE0000027, 32'h0);

    drive(vt[0]);
    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      drive(vt[k]);
      @(negedge clk);
      check("gnt", k, {62'd0, bus.gnt1_o, bus.gnt0_o}, {62'd0, vt[k].g});
      check("sram_cmd", k,
            {15'd0, bus.sram_csb, bus.sram_web, bus.sram_addr, bus.sram_wmask, bus.sram_din},
            {15'd0, ~|vt[k].g, vt[k].web, vt[k].sa, vt[k].sm, vt[k].sd});
      check("rvalid", k, {62'd0, bus.rvalid1_o, bus.rvalid0_o}, {62'd0, vt[k].v});
      check("rdata", k, {bus.rdata1_o, bus.rdata0_o}, {vt[k].q1, vt[k].q0});
    end

    // Write then read of the same address by requester 0 on consecutive grants.
    @(posedge clk); #1;
    drive(idle(1, 32'h12345678, 2'b00, 32'h0, 32'h0));
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req0_i = 1'b1; bus.we0_i = 1'b1; bus.addr0_i = 11'h0AA;
    bus.wmask0_i = 4'hF; bus.wdata0_i = 32'h0BADF00D;
    @(negedge clk);
    check("wr_gnt", 0, {61'd0, bus.gnt0_o, bus.sram_web, bus.sram_csb}, {61'd0, 3'b100});
    @(posedge clk); #1;
    bus.we0_i = 1'b0;
    @(negedge clk);
    check("rd_gnt", 1, {52'd0, bus.gnt0_o, bus.sram_addr}, {52'd0, 1'b1, 11'h0AA});
    @(posedge clk); #1;
    bus.req0_i = 1'b0;
    first_i = -1; second_i = -1; nresp = 0;
    r_first = '1; r_second = '1;
    for (int i = 2; i < 8; i++) begin
      @(negedge clk);
      if (bus.rvalid1_o) check("rvalid1_stray", i, 64'd1, 64'd0);
      if (bus.rvalid0_o) begin
        nresp++;
        if (nresp == 1) begin first_i = i;  r_first = bus.rdata0_o; end
        if (nresp == 2) begin second_i = i; r_second = bus.rdata0_o; end
      end
      @(posedge clk); #1;
    end
    check("resp_count", 2, 64'(nresp), 64'd2);
    check("wr_ack_cycle", 2, 64'(first_i), 64'd2);
    check("wr_ack_data", 2, {32'd0, r_first}, 64'd0);
    check("rd_resp_cycle", 3, 64'(second_i), 64'd3);
    check("rd_resp_data", 3, {32'd0, r_second}, {32'd0, 32'h12345678});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
